// File: rtl/ysyx_22040386_mem_arbiter.sv
// Shares one memory request/response port between the IFU (read-only) and the LSU.
// One transaction is in flight at a time: IDLE (arbitrate) -> REQ (hold request until
// accepted) -> RSP (wait for data, guarded by a timeout counter).
// Optional macro MEM_ARB_RR_EN: round-robin arbitration instead of fixed LSU-over-IFU.
module ysyx_22040386_mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_rsp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_we,
  input  logic [2:0]        lsu_mask_type,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic              lsu_rsp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [2:0]        mem_mask_type,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_timeout
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  // Last counter value at which the RSP wait is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              owner_lsu_q, owner_lsu_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [2:0]        mask_q, mask_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ifu_rsp_q, ifu_rsp_d;
  logic              lsu_rsp_q, lsu_rsp_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d;
  logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;
  logic              any_req;
  logic              grant_lsu;
  logic              accept;
  logic [DATA_W-1:0] rsp_data;

`ifdef MEM_ARB_RR_EN
  // 1 when the IFU won the most recent grant; reset value gives the LSU first turn.
  logic              last_ifu_q, last_ifu_d;
`endif

  // Arbitration: pick the winner and raise its ready while IDLE (never during reset).
  always_comb begin
    any_req = ifu_req_valid | lsu_req_valid;
`ifdef MEM_ARB_RR_EN
    grant_lsu = lsu_req_valid & (~ifu_req_valid | last_ifu_q);
`else
    grant_lsu = lsu_req_valid;
`endif
    accept        = (state_q == IDLE) & ~rst & any_req;
    lsu_req_ready = accept & grant_lsu;
    ifu_req_ready = accept & ~grant_lsu;
  end

  // Next-state logic: latch on accept, hold in REQ, collect the response or time out.
  always_comb begin
    state_d     = state_q;
    owner_lsu_d = owner_lsu_q;
    addr_d      = addr_q;
    we_d        = we_q;
    mask_d      = mask_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    ifu_rsp_d   = 1'b0;
    lsu_rsp_d   = 1'b0;
    err_d       = 1'b0;
    ifu_rdata_d = ifu_rdata_q;
    lsu_rdata_d = lsu_rdata_q;
    rsp_data    = we_q ? '0 : mem_rdata;
`ifdef MEM_ARB_RR_EN
    last_ifu_d  = last_ifu_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = REQ;
          owner_lsu_d = grant_lsu;
`ifdef MEM_ARB_RR_EN
          last_ifu_d  = ~grant_lsu;
`endif
          if (grant_lsu) begin
            addr_d  = lsu_addr;
            we_d    = lsu_we;
            mask_d  = lsu_mask_type;
            wdata_d = lsu_wdata;
          end else begin
            addr_d  = ifu_addr;
            we_d    = 1'b0;
            mask_d  = 3'b011;
            wdata_d = '0;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = RSP;
          cnt_d   = '0;
        end
      end
      RSP: begin
        // A response in the timeout cycle takes precedence over the abort.
        if (mem_rsp_valid || cnt_q == CNT_LAST) begin
          state_d = IDLE;
          err_d   = ~mem_rsp_valid;
          if (!mem_rsp_valid) rsp_data = '1;
          if (owner_lsu_q) begin
            lsu_rsp_d   = 1'b1;
            lsu_rdata_d = rsp_data;
          end else begin
            ifu_rsp_d   = 1'b1;
            ifu_rdata_d = rsp_data;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_lsu_q <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      mask_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      ifu_rsp_q   <= 1'b0;
      lsu_rsp_q   <= 1'b0;
      err_q       <= 1'b0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_ifu_q  <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      owner_lsu_q <= owner_lsu_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      mask_q      <= mask_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      ifu_rsp_q   <= ifu_rsp_d;
      lsu_rsp_q   <= lsu_rsp_d;
      err_q       <= err_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_ifu_q  <= last_ifu_d;
`endif
    end
  end

  // Memory side forwards the latched request only while in REQ.
  always_comb begin
    mem_req_valid = (state_q == REQ);
    mem_we        = we_q;
    mem_mask_type = mask_q;
    mem_addr      = addr_q;
    mem_wdata     = wdata_q;
    ifu_rsp_valid = ifu_rsp_q;
    lsu_rsp_valid = lsu_rsp_q;
    err_timeout   = err_q;
    ifu_rdata     = ifu_rdata_q;
    lsu_rdata     = lsu_rdata_q;
  end

endmodule

// File: tb/tb_ysyx_22040386_mem_arbiter.sv
// Scoreboard bench for ysyx_22040386_mem_arbiter: the stimulus side pushes the
// expected response (owner, data, error flag, cycle) and a monitor pops and compares.
module tb_ysyx_22040386_mem_arbiter;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [63:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_we, lsu_rsp_valid;
  logic [2:0]  lsu_mask_type;
  logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid, err_timeout;
  logic [2:0]  mem_mask_type;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  ysyx_22040386_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_we(lsu_we),
    .lsu_mask_type(lsu_mask_type), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_mask_type(mem_mask_type), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          lsu;
    bit          err;
    logic [63:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  // Requester model: pending requests and their fields.
  bit          ifu_pend = 0, lsu_pend = 0;
  logic [63:0] m_ifu_addr, m_lsu_addr, m_lsu_wdata;
  logic        m_lsu_we;
  logic [2:0]  m_lsu_mask;
  bit          last_ifu = 1;   // round-robin memory: LSU gets the first turn

  // Monitor: any response pulse must match the head of the scoreboard.
  initial begin
    exp_t        e;
    logic [63:0] r_ifu = '0, r_lsu = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        r_ifu = '0;
        r_lsu = '0;
      end
      if (ifu_rsp_valid || lsu_rsp_valid || err_timeout) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_rsp: got ifu=%0b lsu=%0b err=%0b at cycle %0d, expected no response",
                   ifu_rsp_valid, lsu_rsp_valid, err_timeout, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.lsu) r_lsu = e.data; else r_ifu = e.data;
          check("rsp_cycle", 64'(cyc), 64'(e.cyc));
          check("ifu_rsp_valid", {63'd0, ifu_rsp_valid}, {63'd0, !e.lsu});
          check("lsu_rsp_valid", {63'd0, lsu_rsp_valid}, {63'd0, e.lsu});
          check("err_timeout", {63'd0, err_timeout}, {63'd0, e.err});
          check("ifu_rdata", ifu_rdata, r_ifu);
          check("lsu_rdata", lsu_rdata, r_lsu);
        end
      end
    end
  end

  // One full transaction starting at a negedge in IDLE with the pending requests
  // driven. d1 = cycles of mem_req_ready low; d2 = RSP cycle of the response, -1 = none.
  task automatic txn(input int d1, input int d2, input logic [63:0] rdat);
    bit          win_ifu;
    logic [63:0] e_addr, e_wdata;
    logic [2:0]  e_mask;
    logic        e_we;
    exp_t        e;
    ifu_req_valid = ifu_pend;
    lsu_req_valid = lsu_pend;
    ifu_addr      = m_ifu_addr;
    lsu_addr      = m_lsu_addr;
    lsu_we        = m_lsu_we;
    lsu_mask_type = m_lsu_mask;
    lsu_wdata     = m_lsu_wdata;
`ifdef MEM_ARB_RR_EN
    win_ifu = ifu_pend && (!lsu_pend || !last_ifu);
`else
    win_ifu = !lsu_pend;
`endif
    last_ifu = win_ifu;
    if (win_ifu) begin
      e_addr = m_ifu_addr; e_we = 1'b0; e_mask = 3'b011; e_wdata = '0;
    end else begin
      e_addr = m_lsu_addr; e_we = m_lsu_we; e_mask = m_lsu_mask; e_wdata = m_lsu_wdata;
    end
    #1;
    check("ifu_req_ready_idle", {63'd0, ifu_req_ready}, {63'd0, win_ifu});
    check("lsu_req_ready_idle", {63'd0, lsu_req_ready}, {63'd0, !win_ifu});
    @(posedge clk);
    @(negedge clk);
    if (win_ifu) begin ifu_pend = 0; ifu_req_valid = 1'b0; end
    else begin lsu_pend = 0; lsu_req_valid = 1'b0; end
    for (int i = 0; i <= d1; i++) begin
      mem_req_ready = (i == d1);
      #1;
      check("mem_req_valid_req", {63'd0, mem_req_valid}, 64'd1);
      check("mem_addr", mem_addr, e_addr);
      check("mem_we", {63'd0, mem_we}, {63'd0, e_we});
      check("mem_mask_type", {61'd0, mem_mask_type}, {61'd0, e_mask});
      check("mem_wdata", mem_wdata, e_wdata);
      check("ready_busy", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
      @(posedge clk);
      @(negedge clk);
    end
    mem_req_ready = 1'b0;
    if (d2 < 0) begin
      e.lsu = !win_ifu; e.err = 1'b1; e.data = '1; e.cyc = cyc + TO;
      exp_q.push_back(e);
    end
    for (int k = 0; k < TO; k++) begin
      if (k == 0) begin
        #1;
        check("mem_req_valid_rsp", {63'd0, mem_req_valid}, 64'd0);
        check("ready_rsp", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
      end
      if (k == d2) begin
        mem_rsp_valid = 1'b1;
        mem_rdata     = rdat;
        e.lsu = !win_ifu; e.err = 1'b0;
        e.data = (!win_ifu && e_we) ? 64'd0 : rdat;
        e.cyc = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic new_ifu(input logic [63:0] a);
    ifu_pend = 1; m_ifu_addr = a;
  endtask

  task automatic new_lsu(input logic we, input logic [2:0] m, input logic [63:0] a,
                         input logic [63:0] wd);
    lsu_pend = 1; m_lsu_we = we; m_lsu_mask = m; m_lsu_addr = a; m_lsu_wdata = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, d2;
    rst = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 64'h1000; lsu_req_valid = 1'b0; lsu_we = 1'b0;
    lsu_mask_type = '0; lsu_addr = '0; lsu_wdata = '0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("reset_ifu_ready", {63'd0, ifu_req_ready}, 64'd0);
    check("reset_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
    check("reset_mem_addr", mem_addr, 64'd0);
    check("reset_rsp", {61'd0, ifu_rsp_valid, lsu_rsp_valid, err_timeout}, 64'd0);
    check("reset_rdata", ifu_rdata | lsu_rdata, 64'd0);
    ifu_req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Directed: single IFU fetch, then LSU store with delayed ready.
    new_ifu(64'h8000_0000);
    txn(0, 0, 64'h0000_0013_0000_0093);
    new_lsu(1'b1, 3'b010, 64'h8000_1004, 64'hDEAD_BEEF);
    txn(2, 1, 64'h1234_5678_9ABC_DEF0);
    // Both requesters valid and held.
    new_ifu(64'h8000_0008);
    new_lsu(1'b0, 3'b011, 64'h8000_2000, 64'h0);
    txn(0, 0, 64'hAAAA_5555_0000_FFFF);
    txn(1, 2, 64'h0102_0304_0506_0708);
    // Timeout, then response arriving in the timeout cycle.
    new_lsu(1'b0, 3'b000, 64'h8000_3000, 64'h0);
    txn(0, -1, 64'h0);
    new_ifu(64'h8000_0010);
    txn(0, TO - 1, 64'hCAFE_F00D_0000_1111);
    // Stray response while idle.
    mem_rsp_valid = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    @(negedge clk);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      if (!ifu_pend && !lsu_pend && $urandom_range(0, 9) == 0) begin
        mem_rsp_valid = 1'b1; mem_rdata = {$urandom, $urandom};
        @(negedge clk);
        mem_rsp_valid = 1'b0;
      end
      if (!ifu_pend && $urandom_range(0, 1) == 1) new_ifu({$urandom, $urandom});
      if (!lsu_pend && $urandom_range(0, 1) == 1)
        new_lsu(1'($urandom), 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      if (!ifu_pend && !lsu_pend) new_ifu({$urandom, $urandom});
      r = $urandom_range(0, 7);
      d2 = (r == 0) ? -1 : (r == 1) ? TO - 1 : $urandom_range(0, 4);
      txn($urandom_range(0, 3), d2, {$urandom, $urandom});
    end
    while (ifu_pend || lsu_pend) txn(0, 0, {$urandom, $urandom});

    // Asynchronous reset while waiting in RSP.
    new_ifu(64'h8000_0100);
    ifu_req_valid = 1'b1; ifu_addr = m_ifu_addr;
    @(posedge clk);
    @(negedge clk);
    ifu_req_valid = 1'b0; ifu_pend = 0;
    mem_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    ifu_req_valid = 1'b1;
    #1;
    check("arst_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
    check("arst_ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
    check("arst_rsp", {61'd0, ifu_rsp_valid, lsu_rsp_valid, err_timeout}, 64'd0);
    check("arst_rdata", ifu_rdata | lsu_rdata, 64'd0);
    check("arst_mem_fields", mem_addr | mem_wdata | {60'd0, mem_we, mem_mask_type}, 64'd0);
    @(negedge clk);
    ifu_req_valid = 1'b0;
    mem_rsp_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_ifu = 1;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    new_ifu(64'h8000_0200);
    txn(0, 1, 64'h0000_0000_0000_0513);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ysyx_22040386_mem_arbiter.md
Name: ysyx_22040386_mem_arbiter

Overview:
- Shares the single data-memory port (the DPI-backed load/store memory unit) between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Accepts one request at a time, forwards it to the memory side with a valid/ready handshake, and waits for the memory response.
- Routes the response back to the owning requester; a timeout counter guards a response that never arrives.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width
- TIMEOUT, 16, cycles to wait in RSP before aborting; legal range 2..255

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ifu_req_valid  in  1  IFU request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  IFU fetch address
- ifu_rsp_valid  out  1  one-cycle pulse, IFU read data valid
- ifu_rdata  out  DATA_W  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_we  in  1  1 = store, 0 = load
- lsu_mask_type  in  3  size/sign code (000 b, 001 h, 010 w, 011 d; bit2 = unsigned)
- lsu_addr  in  ADDR_W  LSU address
- lsu_wdata  in  DATA_W  store data
- lsu_rsp_valid  out  1  one-cycle pulse, load data valid or store complete
- lsu_rdata  out  DATA_W  load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  forwarded write enable
- mem_mask_type  out  3  forwarded mask type; 3'b011 for IFU
- mem_addr  out  ADDR_W  forwarded address
- mem_wdata  out  DATA_W  forwarded store data; 0 for IFU
- mem_rsp_valid  in  1  memory response
- mem_rdata  in  DATA_W  memory read data
- err_timeout  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async, rst=1):
  - State IDLE; owner register cleared; timeout counter 0; latched request fields 0.
  - All outputs 0.
  - Reset asserted mid-transaction drops the transaction silently; no rsp pulse is issued.
- States: IDLE, REQ, RSP.
- IDLE:
  - Arbitrate among valid requesters. Default is fixed priority, LSU over IFU.
  - The winner's req_ready is driven high combinationally in the same cycle (req_ready = state==IDLE & winner).
  - On that edge, latch addr, we, mask_type, wdata and the owner; go to REQ.
  - With no valid request, stay in IDLE.
- REQ:
  - mem_req_valid=1 with the latched fields held stable.
  - When mem_req_ready=1: go to RSP and clear the counter.
- RSP:
  - mem_req_valid=0. The counter increments each cycle.
  - When mem_rsp_valid=1: pulse the owner's rsp_valid for one cycle, registered, the cycle after.
  - The owner's rdata is registered from mem_rdata. For stores, rdata=0 but rsp_valid still pulses.
  - Return to IDLE.
- Timeout:
  - If the counter reaches TIMEOUT-1 in RSP without mem_rsp_valid, pulse err_timeout.
  - Pulse the owner's rsp_valid with rdata all-ones and return to IDLE.
  - If mem_rsp_valid arrives in the same cycle as the timeout, the response wins and there is no err.
- Ignored inputs:
  - mem_rsp_valid outside RSP is ignored.
  - Requester valids outside IDLE are ignored; ready stays 0.
- Latency: minimum 3 cycles from accept edge to rsp_valid (accept, REQ with ready=1, RSP with rsp_valid=1, registered pulse).
- Throughput: at most one outstanding transaction. The next accept can occur in the IDLE cycle coincident with the rsp pulse.
- rdata outputs hold their value until the next response to the same requester.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration. A last-grant bit flips after each accepted grant.
  - When both requesters are valid, the one not granted last wins. After reset the LSU has priority first.
- Undefined: fixed LSU-over-IFU priority. An IFU request may starve under continuous LSU traffic.

Test Plan:
- Single IFU fetch:
  - Stimulus: addr=0x80000000, mem_req_ready=1 immediately, mem_rsp_valid 1 cycle later with rdata=0x00000013_00000093.
  - Response: ifu_rsp_valid pulses once with that data, 3 cycles after accept; mem_mask_type=011.
- LSU store:
  - Stimulus: addr=0x80001004, mask_type=010, wdata=0xDEADBEEF, mem_req_ready delayed 2 cycles.
  - Response: mem_req_valid held 3 cycles with stable fields; lsu_rsp_valid pulses with lsu_rdata=0.
- Simultaneous IFU and LSU valid, both held:
  - Without MEM_ARB_RR_EN: LSU served twice in a row before IFU only if LSU re-asserts.
  - With MEM_ARB_RR_EN: order is LSU, IFU, LSU.
- Timeout (TIMEOUT=16): never assert mem_rsp_valid -> err_timeout and lsu_rsp_valid pulse together with rdata=0xFFFFFFFF_FFFFFFFF, 16 cycles into RSP; state returns to IDLE.
- Async reset in RSP:
  - Stimulus: assert rst mid-cycle.
  - Response: all outputs 0 immediately; no rsp pulse; a later mem_rsp_valid is ignored; a new IFU request after reset is served normally.
- Stray mem_rsp_valid in IDLE -> no rsp pulse and no state change.
